// File: rtl/ring_code_checker.sv
// One-hot ring code decoder and rotation checker.
// Locks after LOCK_CNT clean rotate-left steps; flags and counts errors.
module ring_code_checker #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         ring_in,
  input  logic                 ring_valid,
  input  logic                 clr_err,
  output logic [$clog2(N)-1:0] index,
  output logic                 onehot_ok,
  output logic                 locked,
  output logic                 seq_err,
  output logic [7:0]           err_count
);

  localparam int IW = $clog2(N);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_LOCKED
  } state_t;

  state_t         r_state, w_state_nx;
  logic [N-1:0]   r_prev, w_prev_nx;
  logic [3:0]     r_match, w_match_nx;
  logic [IW-1:0]  r_index;
  logic           r_ok;
  logic           r_seq_err;
  logic [7:0]     r_err;

  logic           w_onehot;
  logic           w_exp_hit;
  logic [N-1:0]   w_expected;
  logic [IW-1:0]  w_pos;
  logic           w_viol;
  logic           w_err_inc;
  logic [3:0]     w_cnt_inc;

  assign w_onehot   = (ring_in != '0) &&
                      ((ring_in & (ring_in - ONE)) == '0);
  assign w_expected = {r_prev[N-2:0], r_prev[N-1]};
  assign w_exp_hit  = (ring_in == w_expected);
  assign w_cnt_inc  = r_match + 4'd1;

  always_comb begin
    w_pos = '0;
    for (int i = 0; i < N; i++) begin
      if (ring_in[i]) w_pos = IW'(i);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_prev_nx  = r_prev;
    w_match_nx = r_match;
    w_viol     = 1'b0;
    if (ring_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_onehot) begin
            w_state_nx = S_ACQ;
            w_prev_nx  = ring_in;
            w_match_nx = '0;
          end
        end
        S_ACQ: begin
          if (!w_onehot) begin
            w_state_nx = S_IDLE;
          end else if (w_exp_hit) begin
            w_prev_nx  = ring_in;
            w_match_nx = w_cnt_inc;
            if (w_cnt_inc == 4'(LOCK_CNT))
              w_state_nx = S_LOCKED;
          end else begin
            w_prev_nx  = ring_in;
            w_match_nx = '0;
          end
        end
        S_LOCKED: begin
          if (!w_onehot) begin
            w_viol     = 1'b1;
            w_state_nx = S_IDLE;
          end else if (!w_exp_hit) begin
            w_viol     = 1'b1;
            w_state_nx = S_ACQ;
            w_prev_nx  = ring_in;
            w_match_nx = '0;
          end else begin
            w_prev_nx  = ring_in;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // bad codes count in any state; rotation slips only once trusted
  assign w_err_inc = ring_valid & (~w_onehot | w_viol);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_prev    <= '0;
      r_match   <= '0;
      r_index   <= '0;
      r_ok      <= 1'b0;
      r_seq_err <= 1'b0;
      r_err     <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_prev    <= w_prev_nx;
      r_match   <= w_match_nx;
      r_seq_err <= w_viol;
      if (ring_valid) begin
        r_ok <= w_onehot;
        if (w_onehot) r_index <= w_pos;
      end
      if (clr_err)
        r_err <= '0;
      else if (w_err_inc && r_err != 8'hFF)
        r_err <= r_err + 8'd1;
    end
  end

  assign index     = r_index;
  assign onehot_ok = r_ok;
  assign locked    = (r_state == S_LOCKED);
  assign seq_err   = r_seq_err;
  assign err_count = r_err;

endmodule
